// File: rtl/alu_pkg.sv
// alu_pkg: shared flag, result-entry and buffer-state types for the addsub result path.
package alu_pkg;
   localparam int ALU_WIDTH = 32;
   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } alu_flags_t;
   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      alu_flags_t           flags;
   } result_entry_t;
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;
endpackage

// File: rtl/addsub_flags.sv
// addsub_flags: combinational Z/N/C/V generation from addsub operands and sum.
module addsub_flags
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_is_sub,
   input  logic [WIDTH-1:0] i_result,
   output alu_flags_t       o_flags
);
   logic w_am, w_bm, w_sm;
   assign w_am = i_a[WIDTH-1];
   assign w_bm = i_b[WIDTH-1];
   assign w_sm = i_result[WIDTH-1];
   always_comb begin
      o_flags.zero  = (i_result == '0);
      o_flags.neg   = w_sm;
      // subtract reports no-borrow, so carry is simply the unsigned compare
      o_flags.carry = i_is_sub ? (i_a >= i_b) : ((w_am & w_bm) | (w_am & ~w_sm) | (w_bm & ~w_sm));
      o_flags.ovf   = (i_is_sub ? (w_am != w_bm) : (w_am == w_bm)) & (w_sm != w_am);
   end
endmodule

// File: rtl/addsub_result_stage.sv
// addsub_result_stage: registered addsub result + flags behind a 2-entry skid buffer.
// Optional ADDSUB_RESULT_STAGE_STATS_EN adds stat_accepted / stat_stall counters.
module addsub_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_is_sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf
`ifdef ADDSUB_RESULT_STAGE_STATS_EN
   ,
   output logic [31:0]      stat_accepted,
   output logic [31:0]      stat_stall
`endif
);
   typedef struct packed {
      logic [WIDTH-1:0] result;
      alu_flags_t       flags;
   } entry_t;

   state_t     r_state, w_next;
   entry_t     r_main, r_skid, w_in_entry;
   alu_flags_t w_flags;
   logic       w_in_xfer, w_out_xfer;

   addsub_flags #(.WIDTH(WIDTH)) u_flags (
      .i_a      (in_a),
      .i_b      (in_b),
      .i_is_sub (in_is_sub),
      .i_result (in_result),
      .o_flags  (w_flags)
   );

   assign w_in_entry = '{result: in_result, flags: w_flags};
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_EMPTY;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_EMPTY: w_next = w_in_xfer ? ST_ONE : ST_EMPTY;
         ST_ONE:   w_next = (w_in_xfer & ~w_out_xfer) ? ST_FULL : (~w_in_xfer & w_out_xfer) ? ST_EMPTY : ST_ONE;
         ST_FULL:  w_next = w_out_xfer ? ST_ONE : ST_FULL;
         default:  w_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (r_state != ST_EMPTY);
      in_ready  = (r_state != ST_FULL);
   end

   // incoming data bypasses the skid whenever main is free or draining this cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (r_state == ST_FULL && w_out_xfer) r_main <= r_skid;
         else if (w_in_xfer && (r_state == ST_EMPTY || w_out_xfer)) r_main <= w_in_entry;
         if (w_in_xfer && r_state == ST_ONE && !w_out_xfer) r_skid <= w_in_entry;
      end
   end

   assign out_result = r_main.result;
   assign out_zero   = r_main.flags.zero;
   assign out_neg    = r_main.flags.neg;
   assign out_carry  = r_main.flags.carry;
   assign out_ovf    = r_main.flags.ovf;

`ifdef ADDSUB_RESULT_STAGE_STATS_EN
   logic [31:0] r_stat_accepted, r_stat_stall;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stat_accepted <= '0;
         r_stat_stall    <= '0;
      end else begin
         if (w_in_xfer) r_stat_accepted <= r_stat_accepted + 32'd1;
         if (out_valid && !out_ready) r_stat_stall <= r_stat_stall + 32'd1;
      end
   end
   assign stat_accepted = r_stat_accepted;
   assign stat_stall    = r_stat_stall;
`endif
endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage: directed self-checking bench for addsub_result_stage.
module tb_addsub_result_stage;
   logic        CLK = 0, RST = 1;
   logic        in_valid = 0, in_ready, in_is_sub = 0;
   logic [31:0] in_a = 0, in_b = 0, in_result = 0;
   logic        out_valid, out_ready = 0;
   logic [31:0] out_result;
   logic        out_zero, out_neg, out_carry, out_ovf;
   int          total = 0, bad = 0;
`ifdef ADDSUB_RESULT_STAGE_STATS_EN
   logic [31:0] stat_accepted, stat_stall;
`endif

   addsub_result_stage #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_sub(in_is_sub),
      .in_a(in_a), .in_b(in_b), .in_result(in_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf)
`ifdef ADDSUB_RESULT_STAGE_STATS_EN
      , .stat_accepted(stat_accepted), .stat_stall(stat_stall)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic sub);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_is_sub = sub;
      in_result = sub ? a - b : a + b;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({out_valid, in_ready, out_result, out_zero, out_neg, out_carry, out_ovf} !== {1'b0, 1'b1, 32'd0, 4'b0000}) begin
         bad++;
         $display("FAIL reset: got v=%b r=%b res=%h f=%b%b%b%b want v=0 r=1 res=0 f=0000",
                  out_valid, in_ready, out_result, out_zero, out_neg, out_carry, out_ovf);
      end
`ifdef ADDSUB_RESULT_STAGE_STATS_EN
      total++;
      if ({stat_accepted, stat_stall} !== 64'd0) begin
         bad++;
         $display("FAIL reset_stats: got acc=%0d stall=%0d want 0 0", stat_accepted, stat_stall);
      end
`endif
      step();
      RST = 0;
      step();
   endtask

   task automatic test_flags();
      logic [31:0] va [8] = '{32'd312, 32'd312, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'd0};
      logic [31:0] vb [8] = '{32'd1000, 32'd1000, 32'd1, 32'd1, 32'd5, 32'd1, 32'h80000000, 32'd1};
      logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] er [8] = '{32'd1312, 32'hFFFFFD50, 32'h80000000, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF};
      logic [3:0]  ef [8] = '{4'b0000, 4'b0100, 4'b0101, 4'b1010, 4'b1010, 4'b0011, 4'b1011, 4'b0100};
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         drive(1, va[i], vb[i], vs[i]);
         step();
         drive(0, 0, 0, 0);
         total++;
         if ({out_valid, out_result, out_zero, out_neg, out_carry, out_ovf} !== {1'b1, er[i], ef[i]}) begin
            bad++;
            $display("FAIL flags[%0d]: got v=%b res=%h zncv=%b%b%b%b want v=1 res=%h zncv=%b",
                     i, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, er[i], ef[i]);
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      drive(1, 1, 0, 0);
      step();
      drive(1, 2, 0, 0);
      step();
      drive(1, 3, 0, 0);
      total++;
      if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 32'd1}) begin
         bad++;
         $display("FAIL bp_full: got v=%b r=%b res=%0d want v=1 r=0 res=1", out_valid, in_ready, out_result);
      end
      step();
      total++;
      if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 32'd1}) begin
         bad++;
         $display("FAIL bp_hold: got v=%b r=%b res=%0d want v=1 r=0 res=1", out_valid, in_ready, out_result);
      end
      out_ready = 1;
      step();
      total++;
      if ({out_valid, in_ready, out_result} !== {1'b1, 1'b1, 32'd2}) begin
         bad++;
         $display("FAIL bp_out2: got v=%b r=%b res=%0d want v=1 r=1 res=2", out_valid, in_ready, out_result);
      end
      step();
      drive(0, 0, 0, 0);
      total++;
      if ({out_valid, out_result} !== {1'b1, 32'd3}) begin
         bad++;
         $display("FAIL bp_out3: got v=%b res=%0d want v=1 res=3", out_valid, out_result);
      end
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain: got v=%b want v=0", out_valid);
      end
   endtask

   task automatic test_throughput();
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'd10 + i, 0, 0);
         step();
         total++;
         if ({out_valid, in_ready, out_result} !== {1'b1, 1'b1, 32'd10 + i}) begin
            bad++;
            $display("FAIL tput[%0d]: got v=%b r=%b res=%0d want v=1 r=1 res=%0d",
                     i, out_valid, in_ready, out_result, 10 + i);
         end
      end
      drive(0, 0, 0, 0);
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL tput_drain: got v=%b want v=0", out_valid);
      end
   endtask

   task automatic test_reset_full();
      out_ready = 0;
      drive(1, 7, 0, 0);
      step();
      drive(1, 8, 0, 0);
      step();
      drive(0, 0, 0, 0);
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rstfull_pre: got r=%b want r=0", in_ready);
      end
      #2 RST = 1;
      #1;
      total++;
      if ({out_valid, in_ready, out_result} !== {1'b0, 1'b1, 32'd0}) begin
         bad++;
         $display("FAIL rstfull_async: got v=%b r=%b res=%0d want v=0 r=1 res=0", out_valid, in_ready, out_result);
      end
`ifdef ADDSUB_RESULT_STAGE_STATS_EN
      total++;
      if ({stat_accepted, stat_stall} !== 64'd0) begin
         bad++;
         $display("FAIL rstfull_stats: got acc=%0d stall=%0d want 0 0", stat_accepted, stat_stall);
      end
`endif
      step();
      RST = 0;
      step();
      total++;
      if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rstfull_after: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_flags();
      test_backpressure();
      test_throughput();
      test_reset_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
